// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM sharing one prescaled counter, with double-buffered duty registers.
// Define PWM_CENTER_ALIGN_EN for an up/down (centre-aligned) counter; the default build is edge-aligned.
module pwm_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int DIV_W    = 16,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [DIV_W-1:0]    prescale,
  input  logic [WIDTH-1:0]    period,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_duty,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  logic [DIV_W-1:0] r_pre_cnt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_p_act;
  logic [WIDTH-1:0] r_duty_sh  [CHANNELS];
  logic [WIDTH-1:0] r_duty_act [CHANNELS];
  logic             r_bnd;
  logic             w_tick;
  logic             w_bnd;
  logic [WIDTH-1:0] w_cnt_nxt;

  assign w_tick = (r_pre_cnt == prescale);

`ifdef PWM_CENTER_ALIGN_EN
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
  dir_t r_dir;
  dir_t w_dir_nxt;

  // Boundary is the step back to 0 while descending; P_act<=1 never has a distinct down leg.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    w_bnd     = 1'b0;
    if (r_dir == DIR_UP) begin
      if (r_cnt >= r_p_act) begin
        if (r_p_act <= WIDTH'(1)) begin
          w_cnt_nxt = '0;
          w_bnd     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - WIDTH'(1);
          w_dir_nxt = DIR_DOWN;
        end
      end else begin
        w_cnt_nxt = r_cnt + WIDTH'(1);
      end
    end else begin
      if (r_cnt <= WIDTH'(1)) begin
        w_cnt_nxt = '0;
        w_dir_nxt = DIR_UP;
        w_bnd     = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt - WIDTH'(1);
      end
    end
  end
`else
  always_comb begin
    w_bnd     = (r_cnt == r_p_act);
    w_cnt_nxt = w_bnd ? '0 : r_cnt + WIDTH'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt    <= '0;
      r_cnt        <= '0;
      r_p_act      <= '1;
      r_bnd        <= 1'b0;
      pwm_out      <= '0;
      period_start <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      r_dir        <= DIR_UP;
`endif
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_duty_sh[i]  <= '0;
        r_duty_act[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (wr_en && (wr_ch == CH_W'(i))) r_duty_sh[i] <= wr_duty;
      end
      if (!enable) begin
        r_pre_cnt    <= '0;
        r_cnt        <= '0;
        r_p_act      <= period;
        r_bnd        <= 1'b0;
        pwm_out      <= '0;
        period_start <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        r_dir        <= DIR_UP;
`endif
        for (int unsigned i = 0; i < CHANNELS; i++) r_duty_act[i] <= r_duty_sh[i];
      end else begin
        r_pre_cnt    <= w_tick ? '0 : r_pre_cnt + DIV_W'(1);
        // Boundary flag is delayed one clock so period_start lines up with the cnt=0 output.
        r_bnd        <= w_tick && w_bnd;
        period_start <= r_bnd;
        if (w_tick) begin
          r_cnt <= w_cnt_nxt;
`ifdef PWM_CENTER_ALIGN_EN
          r_dir <= w_dir_nxt;
`endif
          if (w_bnd) begin
            r_p_act <= period;
            for (int unsigned i = 0; i < CHANNELS; i++) r_duty_act[i] <= r_duty_sh[i];
          end
        end
        for (int unsigned i = 0; i < CHANNELS; i++) pwm_out[i] <= (r_cnt < r_duty_act[i]);
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: high-time and period arithmetic checked against randomized duty/period settings.
module tb_pwm_multi;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic [15:0]    prescale = '0;
  logic [7:0]     period = '0;
  logic           wr_en = 1'b0;
  logic [2:0]     wr_ch = '0;
  logic [7:0]     wr_duty = '0;
  logic [NCH-1:0] pwm_out;
  logic           period_start;

  int errors = 0;
  int checks = 0;
  int m_hi [NCH];
  int m_ps_mid;
  bit m_ps_end;

  pwm_multi #(.CHANNELS(NCH), .WIDTH(8), .DIV_W(16), .CH_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .prescale(prescale), .period(period),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty), .pwm_out(pwm_out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  // Period length in clocks from the counting rules.
  function automatic int exp_len(int p, int ps);
`ifdef PWM_CENTER_ALIGN_EN
    return ((p == 0) ? 1 : 2 * p) * (ps + 1);
`else
    return (p + 1) * (ps + 1);
`endif
  endfunction

  // High clocks per period for duty d.
  function automatic int exp_high(int d, int p, int ps);
`ifdef PWM_CENTER_ALIGN_EN
    if (d == 0) return 0;
    if (d > p) return exp_len(p, ps);
    return (2 * d - 1) * (ps + 1);
`else
    return ((d > p) ? (p + 1) : d) * (ps + 1);
`endif
  endfunction

  task automatic setup(input int p, input int ps);
    @(negedge clk);
    enable   = 1'b0;
    period   = 8'(p);
    prescale = 16'(ps);
  endtask

  task automatic write_duty(input int ch, input int d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_ch   = 3'(ch);
    wr_duty = 8'(d);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_ps(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (period_start === 1'b1) ok = 1'b1;
    end
  endtask

  // Starts on the clock showing period_start; ends on the clock one period later.
  task automatic measure(input int len);
    for (int c = 0; c < NCH; c++) m_hi[c] = 0;
    m_ps_mid = 0;
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge clk);
      for (int c = 0; c < NCH; c++) if (pwm_out[c] === 1'b1) m_hi[c]++;
      if (k > 0 && period_start !== 1'b0) m_ps_mid++;
    end
    @(negedge clk);
    m_ps_end = (period_start === 1'b1);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (pwm_out !== '0 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_init pwm_out=%b period_start=%b required 0000/0", pwm_out, period_start);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    setup(255, 0);
    write_duty(0, 8'h80);
    @(negedge clk);
    enable = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (pwm_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_prerun pwm_out[0]=%b required 1", pwm_out[0]);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== '0 || period_start !== 1'b0 || dut.r_cnt !== 8'd0 || dut.r_p_act !== 8'hFF) begin
      errors++;
      $display("FAIL reset_async pwm_out=%b ps=%b cnt=%0d p_act=%0d required 0000/0/0/255",
               pwm_out, period_start, dut.r_cnt, dut.r_p_act);
    end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (pwm_out !== '0) begin
      errors++;
      $display("FAIL reset_release pwm_out=%b required 0000", pwm_out);
    end
  endtask

  task automatic test_duty_sweep();
    bit ok;
    int d [NCH];
    d = '{8'h00, 8'h40, 8'h80, 8'hC0};
    setup(255, 0);
    for (int c = 0; c < NCH; c++) write_duty(c, d[c]);
    @(negedge clk);
    enable = 1'b1;
    wait_ps(1200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sweep_timeout period_start=0 required 1");
    end
    measure(exp_len(255, 0));
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (m_hi[c] != exp_high(d[c], 255, 0)) begin
        errors++;
        $display("FAIL sweep_ch%0d high=%0d required %0d", c, m_hi[c], exp_high(d[c], 255, 0));
      end
    end
    checks++;
    if (m_ps_mid != 0 || !m_ps_end) begin
      errors++;
      $display("FAIL sweep_period extra_pulses=%0d end_pulse=%0d required 0/1", m_ps_mid, m_ps_end);
    end
  endtask

  task automatic test_prescale();
    bit ok;
    setup(9, 3);
    write_duty(0, 5);
    @(negedge clk);
    enable = 1'b1;
    wait_ps(400, ok);
    measure(40);
    checks++;
    if (!ok || m_hi[0] != exp_high(5, 9, 3) || m_hi[0] != 20 || !m_ps_end || m_ps_mid != 0) begin
      errors++;
      $display("FAIL prescale_d5 found=%0d high=%0d end=%0d mid=%0d required 1/20/1/0",
               ok, m_hi[0], m_ps_end, m_ps_mid);
    end
    write_duty(0, 10);
    wait_ps(400, ok);
    measure(40);
    checks++;
    if (!ok || m_hi[0] != 40 || !m_ps_end) begin
      errors++;
      $display("FAIL prescale_d10 found=%0d high=%0d end=%0d required 1/40/1", ok, m_hi[0], m_ps_end);
    end
  endtask

  task automatic test_shadow();
    bit ok;
    int b [4];
    int c1;
    setup(255, 0);
    write_duty(0, 8'h40);
    write_duty(1, 8'h10);
    @(negedge clk);
    enable = 1'b1;
    wait_ps(1200, ok);
    b = '{0, 0, 0, 0};
    c1 = 0;
    // cnt during clock S+k is k+1, so k=254 is the boundary tick.
    for (int k = 0; k < 1024; k++) begin
      if (k > 0) @(negedge clk);
      if (pwm_out[0] === 1'b1) b[k / 256]++;
      if (pwm_out[1] === 1'b1) c1++;
      wr_en = 1'b0;
      if (k == 100) begin wr_en = 1'b1; wr_ch = 3'd0; wr_duty = 8'h20; end
      if (k == 254) begin wr_en = 1'b1; wr_ch = 3'd0; wr_duty = 8'h60; end
      if (k == 300) begin wr_en = 1'b1; wr_ch = 3'd4; wr_duty = 8'hF0; end
      if (k == 320) begin wr_en = 1'b1; wr_ch = 3'd5; wr_duty = 8'hF0; end
    end
    wr_en = 1'b0;
    checks++;
    if (!ok || b[0] != 8'h40 || b[1] != 8'h20 || b[2] != 8'h60) begin
      errors++;
      $display("FAIL shadow_seq found=%0d highs=%0d/%0d/%0d required 64/32/96", ok, b[0], b[1], b[2]);
    end
    checks++;
    if (b[3] != 8'h60 || c1 != 4 * 8'h10) begin
      errors++;
      $display("FAIL shadow_badch ch0=%0d ch1=%0d required 96/64", b[3], c1);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int n;
    setup(255, 0);
    write_duty(2, 8'h80);
    @(negedge clk);
    enable = 1'b1;
    wait_ps(1200, ok);
    repeat (99) @(negedge clk);
    checks++;
    if (!ok || pwm_out[2] !== 1'b1) begin
      errors++;
      $display("FAIL drop_before found=%0d pwm_out[2]=%b required 1/1", ok, pwm_out[2]);
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (pwm_out !== '0 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL drop_after pwm_out=%b ps=%b required 0000/0", pwm_out, period_start);
    end
    period = 8'd19;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      n++;
      if (period_start === 1'b1) ok = 1'b1;
    end
    // P+1 ticks to the first boundary, plus the registered-output lag.
    checks++;
    if (!ok || n != 19 + 2) begin
      errors++;
      $display("FAIL reenable_first found=%0d clocks=%0d required 1/21", ok, n);
    end
    measure(exp_len(19, 0));
    checks++;
    if (!m_ps_end || m_ps_mid != 0 || m_hi[2] != 20) begin
      errors++;
      $display("FAIL reenable_period end=%0d mid=%0d high2=%0d required 1/0/20", m_ps_end, m_ps_mid, m_hi[2]);
    end
  endtask

  task automatic test_random();
    bit ok;
    int p, ps, len;
    int d [NCH];
    for (int it = 0; it < 6; it++) begin
      p  = int'($urandom_range(1, 20));
      ps = int'($urandom_range(0, 3));
      setup(p, ps);
      for (int c = 0; c < NCH; c++) begin
        d[c] = int'($urandom_range(0, p + 2));
        write_duty(c, d[c]);
      end
      @(negedge clk);
      enable = 1'b1;
      len = exp_len(p, ps);
      wait_ps(4 * len + 20, ok);
      measure(len);
      checks++;
      if (!ok || !m_ps_end || m_ps_mid != 0) begin
        errors++;
        $display("FAIL rand%0d_period P=%0d ps=%0d found=%0d end=%0d mid=%0d required 1/1/0",
                 it, p, ps, ok, m_ps_end, m_ps_mid);
      end
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if (m_hi[c] != exp_high(d[c], p, ps)) begin
          errors++;
          $display("FAIL rand%0d_ch%0d P=%0d ps=%0d D=%0d high=%0d required %0d",
                   it, c, p, ps, d[c], m_hi[c], exp_high(d[c], p, ps));
        end
      end
    end
  endtask

`ifdef PWM_CENTER_ALIGN_EN
  task automatic test_center();
    bit ok;
    bit h [16];
    int cnt;
    setup(8, 0);
    write_duty(0, 3);
    @(negedge clk);
    enable = 1'b1;
    wait_ps(200, ok);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      h[k] = (pwm_out[0] === 1'b1);
      if (h[k]) cnt++;
    end
    @(negedge clk);
    checks++;
    if (!ok || cnt != 5 || period_start !== 1'b1) begin
      errors++;
      $display("FAIL center_period found=%0d high=%0d end_ps=%b required 1/5/1", ok, cnt, period_start);
    end
    checks++;
    if (!(h[0] && h[1] && h[2] && h[14] && h[15]) || h[3] || h[13]) begin
      errors++;
      $display("FAIL center_align h0..3=%0d%0d%0d%0d h13..15=%0d%0d%0d required 1110/011",
               h[0], h[1], h[2], h[3], h[13], h[14], h[15]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_duty_sweep();
    test_prescale();
    test_random();
`ifdef PWM_CENTER_ALIGN_EN
    test_center();
`else
    test_shadow();
    test_enable_drop();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator with prescaled timebase, per-channel double-buffered duty registers and a runtime period. It drives LED/motor outputs on the DE10-Lite and generalises the single-channel, fixed-256-step PWM. Register writes arrive from a simple write strobe. All channels share one counter so their edges stay phase-locked.

## Interface
- `CHANNELS`, default 4: number of PWM outputs (1..32).
- `WIDTH`, default 8: counter, period and duty width.
- `DIV_W`, default 16: prescaler width.
- `CH_W`, default `$clog2(CHANNELS)` (minimum 1): channel index width.
- `clk`  in  1: system clock, 50 MHz.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `enable`  in  1: runs the timebase.
- `prescale`  in  DIV_W: tick every `prescale+1` clocks.
- `period`  in  WIDTH: counter terminal value `P`.
- `wr_en`  in  1: duty write strobe.
- `wr_ch`  in  CH_W: channel select.
- `wr_duty`  in  WIDTH: duty value `D`.
- `pwm_out`  out  CHANNELS: PWM outputs, registered.
- `period_start`  out  1: one-clock pulse at each period boundary, registered.

## Operation
- **Prescaler**
  - `pre_cnt` counts 0..`prescale`, wraps to 0, and asserts `tick` when `pre_cnt==prescale`.
  - `prescale=0` gives a tick every clock.
  - A `prescale` change takes effect at the next compare.
- **Counter (edge-aligned)**
  - `cnt` advances on `tick`: 0,1,…,`P_act`, then 0.
  - Period = `P_act+1` ticks. `P_act=0` gives a 1-tick period.
- **Boundary**
  - Occurs on the tick where `cnt==P_act`, as the counter wraps.
  - At the boundary: `P_act<=period`, every `duty_act[i]<=duty_sh[i]`, and `period_start` pulses.
- **Writes**
  - When `wr_en` is high, `duty_sh[wr_ch]<=wr_duty`.
  - Writes with `wr_ch>=CHANNELS` are ignored.
  - A write coincident with a boundary lands in the shadow only. The active register loads the pre-write shadow value, so the new value applies from the following boundary.
- **Compare**
  - `pwm_out[i]` is registered as `cnt < duty_act[i]`, giving `D` high ticks per period.
  - `D=0`: constant low.
  - `D>P_act`: constant high.
  - With `P=2^WIDTH-1`, full-on is unreachable; software sets `P<=2^WIDTH-2` when 100% is needed.
- **Disable**
  - While `enable=0`: `pre_cnt`/`cnt` are held at 0, `pwm_out=0`, `period_start=0`, and `P_act`/`duty_act` track `period`/`duty_sh` every clock.
  - When `enable` rises, the first period starts at `cnt=0` using the values at that moment.
  - Dropping `enable` mid-period aborts the period immediately. There is no completion.
- **Reset** (async assert, sync deassert in the reset tree)
  - `pre_cnt=0`, `cnt=0`, all `duty_sh`/`duty_act=0`, `P_act={WIDTH{1'b1}}`, `pwm_out=0`, `period_start=0`.
  - Asserting reset mid-period forces all of these immediately, without waiting for a clock.

## Timing
- `pwm_out` lags `cnt` by one clock (registered compare).
- `period_start` is high for exactly one clock: the clock after the boundary tick, aligned with `pwm_out` for `cnt=0`.
- A duty write in clock `n` is visible on `pwm_out` one clock after the next boundary that occurs after clock `n`.
- Steady state gives an output period of `(P+1)*(prescale+1)` clocks (edge mode).
- No combinational paths from inputs to outputs.

## Configuration
- `PWM_CENTER_ALIGN_EN` defined:
  - Counter runs up/down: 0,1,…,`P_act`,`P_act-1`,…,1, then 0.
  - Period = `2*P_act` ticks, or 1 tick when `P_act=0`.
  - The boundary is the tick where `cnt` returns to 0 counting down.
  - The compare is unchanged, so high time is `2D-1` ticks for `1<=D<=P_act`. `D=0` gives low and `D>P_act` gives constant high. The pulse is centred on the boundary.
  - Direction register reset value: up.
- Not defined:
  - Edge-aligned counter only. No direction logic is synthesised.

## Test plan
- **Reset**: assert `rst_n=0` mid-run with `enable=1`, `D=0x80`. Outputs must be 0 and `cnt`=0 asynchronously. After release with `enable=0`, `pwm_out=0`.
- **Duty sweep**: `prescale=0`, `P=255`, write ch0..3 = 0x00/0x40/0x80/0xC0, `enable=1`. Per 256 clocks, high counts must be 0/64/128/192. `period_start` pulses every 256 clocks.
- **Prescale**: `prescale=3`, `P=9`, `D=5`. Output must be high 20 of every 40 clocks. `D=10` gives constant high.
- **Shadow**: write ch0 `D=0x20` mid-period, then `D=0x60` on the boundary tick. The current period keeps its old duty, the next period uses 0x20, and the one after uses 0x60. `wr_ch=CHANNELS` is ignored.
- **Enable drop**: drop `enable` at `cnt=100`. Outputs low next clock. Re-enable: first `period_start` after `P+1` ticks, with the new `period` applied.
- **Center** (`PWM_CENTER_ALIGN_EN`): `P=8`, `D=3`, `prescale=0`. Period is 16 clocks, 5 of them high, centred on `period_start`.
